flag_branch_unit: RTL and testbench

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

---
 rtl/flag_branch_unit.sv | 186 ++++++++++++++++++
 tb/tb_flag_branch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Flag register plus a three-state conditional-branch sequencer that owns the 9-bit program counter.
// Optional branch-and-link support (br_link input, lr output) is enabled by defining BRANCH_LINK_EN.
module flag_branch_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] Z,
  input  logic       loads,
  input  logic       pc_inc,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [2:0] br_cond,
  input  logic [7:0] br_imm,
  output logic [8:0] pc,
  output logic [2:0] flags,
  output logic       taken,
`ifdef BRANCH_LINK_EN
  input  logic       br_link,
  output logic [8:0] lr,
`endif
  output logic       br_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    C_B   = 3'b000,
    C_BEQ = 3'b001,
    C_BNE = 3'b010,
    C_BLT = 3'b011,
    C_BLE = 3'b100
  } cond_e;

  state_e     state_q, state_d;
  logic [2:0] flags_q;
  logic [2:0] cond_q;
  logic [7:0] imm_q;
  logic       res_q, res_d;
  logic [8:0] pc_q, pc_d;
  logic       taken_q;
  logic       br_done_q;

  logic accept;
  logic eval_en;
  logic commit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (br_valid) state_d = S_EVAL;
      S_EVAL:   state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: output logic
  always_comb begin
    br_ready = 1'b0;
    eval_en  = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      S_IDLE:   br_ready = 1'b1;
      S_EVAL:   eval_en  = 1'b1;
      S_UPDATE: commit   = 1'b1;
      default:  br_ready = 1'b0;
    endcase
  end

  assign accept = br_ready & br_valid;

  // ---------------------------------------------------------------------------
  // Flag register: loads in any state, so a same-edge load+accept is seen in EVAL
  // while a load during EVAL only lands after the result is already registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   flags_q <= 3'b000;
    else if (loads) flags_q <= Z;
  end

  // Request capture at accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= 3'b000;
      imm_q  <= 8'h00;
    end else if (accept) begin
      cond_q <= br_cond;
      imm_q  <= br_imm;
    end
  end

  // ---------------------------------------------------------------------------
  // Condition evaluation against the flag register (Z[0]=zero, N, V)
  // ---------------------------------------------------------------------------
  always_comb begin
    res_d = 1'b0;
    unique case (cond_q)
      C_B:     res_d = 1'b1;
      C_BEQ:   res_d = flags_q[0];
      C_BNE:   res_d = ~flags_q[0];
      C_BLT:   res_d = flags_q[1] ^ flags_q[2];
      C_BLE:   res_d = (flags_q[1] ^ flags_q[2]) | flags_q[0];
      default: res_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     res_q <= 1'b0;
    else if (eval_en) res_q <= res_d;
  end

  // ---------------------------------------------------------------------------
  // Program counter: branch commit has priority; sequential advance only when
  // idle with no branch request. All arithmetic wraps modulo 512.
  // ---------------------------------------------------------------------------
  logic [8:0] pc_seq;
  logic [8:0] imm_ext;

  assign pc_seq  = pc_q + 9'd1;
  assign imm_ext = {imm_q[7], imm_q};

  always_comb begin
    pc_d = pc_q;
    if (commit) begin
      pc_d = res_q ? (pc_seq + imm_ext) : pc_seq;
    end else if (br_ready && pc_inc && !br_valid) begin
      pc_d = pc_seq;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= 9'd0;
    else          pc_q <= pc_d;
  end

  // Resolution outputs: br_done pulses for the cycle after the UPDATE edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_q   <= 1'b0;
      br_done_q <= 1'b0;
    end else begin
      br_done_q <= commit;
      if (commit) taken_q <= res_q;
    end
  end

`ifdef BRANCH_LINK_EN
  logic       link_q;
  logic [8:0] lr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    link_q <= 1'b0;
    else if (accept) link_q <= br_link;
  end

  // Link address is the fall-through pc, written whether or not the branch is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               lr_q <= 9'd0;
    else if (commit && link_q)  lr_q <= pc_seq;
  end

  assign lr = lr_q;
`endif

  assign pc      = pc_q;
  assign flags   = flags_q;
  assign taken   = taken_q;
  assign br_done = br_done_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit; define BRANCH_LINK_EN to also cover the link feature.
module tb_flag_branch_unit;

  localparam logic [2:0] C_B   = 3'b000;
  localparam logic [2:0] C_BEQ = 3'b001;
  localparam logic [2:0] C_BNE = 3'b010;
  localparam logic [2:0] C_BLT = 3'b011;
  localparam logic [2:0] C_BLE = 3'b100;
  localparam logic [2:0] C_RSV = 3'b101;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] Z;
  logic       loads;
  logic       pc_inc;
  logic       br_valid;
  logic       br_ready;
  logic [2:0] br_cond;
  logic [7:0] br_imm;
  logic [8:0] pc;
  logic [2:0] flags;
  logic       taken;
  logic       br_done;
`ifdef BRANCH_LINK_EN
  logic       br_link;
  logic [8:0] lr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flag_branch_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Z        (Z),
    .loads    (loads),
    .pc_inc   (pc_inc),
    .br_valid (br_valid),
    .br_ready (br_ready),
    .br_cond  (br_cond),
    .br_imm   (br_imm),
    .pc       (pc),
    .flags    (flags),
    .taken    (taken),
`ifdef BRANCH_LINK_EN
    .br_link  (br_link),
    .lr       (lr),
`endif
    .br_done  (br_done)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic incs(input int n);
    pc_inc = 1'b1;
    repeat (n) tick();
    pc_inc = 1'b0;
  endtask

  task automatic load(input logic [2:0] z);
    Z = z;
    loads = 1'b1;
    tick();
    loads = 1'b0;
  endtask

  // Issues one request and waits (bounded) for br_done; lat = edges from accept to br_done visible.
  task automatic do_branch(input logic [2:0] c, input logic [7:0] imm,
                           input logic ld, input logic [2:0] z, output int lat);
    br_cond  = c;
    br_imm   = imm;
    br_valid = 1'b1;
    loads    = ld;
    Z        = z;
    tick();
    br_valid = 1'b0;
    loads    = 1'b0;
    lat = 1;
    while (!br_done && lat < 8) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (pc !== 9'd0)    begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if (flags !== 3'd0) begin errors++; $display("FAIL reset_flags: got %b expected 000", flags); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", br_ready); end
    checks++; if (br_done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", br_done); end
    checks++; if (taken !== 1'b0)    begin errors++; $display("FAIL reset_taken: got %b expected 0", taken); end
    reset_n = 1'b1;
    tick();
    checks++; if (pc !== 9'd0) begin errors++; $display("FAIL reset_idle_pc: got %0d expected 0", pc); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    pc_inc = 1'b1;
    repeat (511) tick();
    checks++; if (pc !== 9'd511) begin errors++; $display("FAIL wrap_511: got %0d expected 511", pc); end
    tick();
    checks++; if (pc !== 9'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", pc); end
    tick();
    pc_inc = 1'b0;
    checks++; if (pc !== 9'd1) begin errors++; $display("FAIL wrap_end: got %0d expected 1", pc); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL wrap_flags: got %b expected 000", flags); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b expected 1", br_ready); end
  endtask

  task automatic test_beq_bne();
    int lat;
    do_reset();
    incs(10);
    load(3'b001);
    checks++; if (flags !== 3'b001) begin errors++; $display("FAIL load_flags: got %b expected 001", flags); end
    do_branch(C_BEQ, 8'd5, 1'b0, 3'b000, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL beq_latency: got %0d expected 3", lat); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b expected 1", taken); end
    checks++; if (pc !== 9'd16) begin errors++; $display("FAIL beq_pc: got %0d expected 16", pc); end
    tick();
    checks++; if (br_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", br_done); end
    do_branch(C_BNE, 8'd5, 1'b0, 3'b000, lat);
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL bne_taken: got %b expected 0", taken); end
    checks++; if (pc !== 9'd17) begin errors++; $display("FAIL bne_pc: got %0d expected 17", pc); end
  endtask

  task automatic test_blt();
    int lat;
    do_reset();
    incs(100);
    load(3'b010);
    do_branch(C_BLT, 8'hF6, 1'b0, 3'b000, lat);
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b expected 1", taken); end
    checks++; if (pc !== 9'd91) begin errors++; $display("FAIL blt_pc: got %0d expected 91", pc); end
    incs(9);
    load(3'b110);
    do_branch(C_BLT, 8'hF6, 1'b0, 3'b000, lat);
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL blt_nv_taken: got %b expected 0", taken); end
    checks++; if (pc !== 9'd101) begin errors++; $display("FAIL blt_nv_pc: got %0d expected 101", pc); end
  endtask

  task automatic test_ble_reserved();
    int lat;
    do_reset();
    load(3'b001);
    do_branch(C_BLE, 8'd7, 1'b0, 3'b000, lat);
    checks++; if (pc !== 9'd8) begin errors++; $display("FAIL ble_z_pc: got %0d expected 8", pc); end
    load(3'b000);
    do_branch(C_BLE, 8'd7, 1'b0, 3'b000, lat);
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL ble_clear_taken: got %b expected 0", taken); end
    checks++; if (pc !== 9'd9) begin errors++; $display("FAIL ble_clear_pc: got %0d expected 9", pc); end
    do_branch(C_RSV, 8'd7, 1'b0, 3'b000, lat);
    checks++; if (taken !== 1'b0) begin errors++; $display("FAIL rsv_taken: got %b expected 0", taken); end
    checks++; if (pc !== 9'd10) begin errors++; $display("FAIL rsv_pc: got %0d expected 10", pc); end
    // Backward wrap below zero: 10 + 1 - 128 = -117 -> 395
    do_branch(C_B, 8'h80, 1'b0, 3'b000, lat);
    checks++; if (pc !== 9'd395) begin errors++; $display("FAIL b_wrap_pc: got %0d expected 395", pc); end
  endtask

  task automatic test_load_hazards();
    int lat;
    do_reset();
    do_branch(C_BEQ, 8'd3, 1'b1, 3'b001, lat);
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL same_edge_taken: got %b expected 1", taken); end
    checks++; if (pc !== 9'd4) begin errors++; $display("FAIL same_edge_pc: got %0d expected 4", pc); end
    br_cond  = C_BEQ;
    br_imm   = 8'd0;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    Z = 3'b000;
    loads = 1'b1;
    tick();
    loads = 1'b0;
    tick();
    checks++; if (br_done !== 1'b1) begin errors++; $display("FAIL eval_load_done: got %b expected 1", br_done); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL eval_load_taken: got %b expected 1", taken); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL eval_load_flags: got %b expected 000", flags); end
  endtask

  task automatic test_pc_inc_with_branch();
    int lat;
    do_reset();
    incs(7);
    pc_inc = 1'b1;
    do_branch(C_B, 8'hFE, 1'b0, 3'b000, lat);
    pc_inc = 1'b0;
    checks++; if (pc !== 9'd6) begin errors++; $display("FAIL inc_branch_pc: got %0d expected 6", pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    br_cond  = C_B;
    br_imm   = 8'd0;
    br_valid = 1'b1;
    tick();
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_eval: got %b expected 0", br_ready); end
    tick();
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_upd: got %b expected 0", br_ready); end
    tick();
    checks++; if (br_done !== 1'b1 || pc !== 9'd1) begin errors++; $display("FAIL b2b_first: got done=%b pc=%0d expected done=1 pc=1", br_done, pc); end
    tick();
    checks++; if (br_done !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", br_done); end
    tick();
    tick();
    br_valid = 1'b0;
    checks++; if (br_done !== 1'b1 || pc !== 9'd2) begin errors++; $display("FAIL b2b_second: got done=%b pc=%0d expected done=1 pc=2", br_done, pc); end
  endtask

  task automatic test_reset_in_eval();
    int lat;
    logic seen;
    do_reset();
    incs(5);
    br_cond  = C_B;
    br_imm   = 8'd4;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL rst_eval_state: got ready=%b expected 0", br_ready); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pc !== 9'd0 || br_ready !== 1'b1) begin errors++; $display("FAIL rst_async: got pc=%0d ready=%b expected pc=0 ready=1", pc, br_ready); end
    #1 reset_n = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (br_done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b expected 0", seen); end
    checks++; if (pc !== 9'd0) begin errors++; $display("FAIL rst_pc_held: got %0d expected 0", pc); end
    do_branch(C_B, 8'd2, 1'b0, 3'b000, lat);
    checks++; if (lat !== 3 || pc !== 9'd3) begin errors++; $display("FAIL rst_next_branch: got lat=%0d pc=%0d expected lat=3 pc=3", lat, pc); end
  endtask

`ifdef BRANCH_LINK_EN
  task automatic test_link();
    int lat;
    do_reset();
    checks++; if (lr !== 9'd0) begin errors++; $display("FAIL lr_reset: got %0d expected 0", lr); end
    incs(20);
    br_link = 1'b1;
    do_branch(C_B, 8'd3, 1'b0, 3'b000, lat);
    checks++; if (pc !== 9'd24 || lr !== 9'd21) begin errors++; $display("FAIL link_b: got pc=%0d lr=%0d expected pc=24 lr=21", pc, lr); end
    br_link = 1'b0;
    do_branch(C_B, 8'd0, 1'b0, 3'b000, lat);
    checks++; if (pc !== 9'd25 || lr !== 9'd21) begin errors++; $display("FAIL nolink_hold: got pc=%0d lr=%0d expected pc=25 lr=21", pc, lr); end
    br_link = 1'b1;
    do_branch(C_RSV, 8'd9, 1'b0, 3'b000, lat);
    br_link = 1'b0;
    checks++; if (pc !== 9'd26 || lr !== 9'd26) begin errors++; $display("FAIL link_not_taken: got pc=%0d lr=%0d expected pc=26 lr=26", pc, lr); end
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    Z        = 3'b000;
    loads    = 1'b0;
    pc_inc   = 1'b0;
    br_valid = 1'b0;
    br_cond  = 3'b000;
    br_imm   = 8'h00;
`ifdef BRANCH_LINK_EN
    br_link  = 1'b0;
`endif
    test_reset();
    test_pc_wrap();
    test_beq_bne();
    test_blt();
    test_ble_reserved();
    test_load_hazards();
    test_pc_inc_with_branch();
    test_back_to_back();
    test_reset_in_eval();
`ifdef BRANCH_LINK_EN
    test_link();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
